// File: rtl/vga_timing_gen.sv
// 1280x1024@60 raster timing: pixel coordinates, display enable, syncs, line/frame strobes.
// All outputs are registered, 1 VGA_CLK behind the counters; free-running with no stall input.
module vga_timing_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BACK    = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 38,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic        VGA_CLK,
  input  logic        rst_n,
  output logic        disp_en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        h_vis;
  logic        v_vis;
  logic        hs_act;
  logic        vs_act;

  always_comb begin
    h_wrap = (h_cnt == H_MAX);
    v_wrap = (v_cnt == V_MAX);
    h_vis  = (h_cnt < H_VIS);
    v_vis  = (v_cnt < V_VIS);
    hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    // vsync spans whole lines, blanking included
    vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      disp_en     <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? 11'd0 : h_cnt + 11'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
      end
      disp_en     <= h_vis && v_vis;
      x           <= h_vis ? h_cnt : 11'd0;
      y           <= v_vis ? v_cnt : 11'd0;
      hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      line_start  <= (h_cnt == 11'd0);
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end
  end

endmodule
